// File: rtl/fx_pkg.sv
// Shared definitions for the FX sidechain detector and compressor gain stage.
package fx_pkg;

  typedef enum logic [1:0] {IDLE, PEAK, SMOOTH} env_state_t;

  localparam int ENV_FRAC_W     = 8;
  localparam int ATK_SHIFT_BASE = 1;
  localparam int REL_SHIFT_BASE = 4;
  localparam int LVL_W          = 32;

  // Control value -> sample-domain level; the compressor uses the same mapping.
  function automatic logic [LVL_W-1:0] level_from_param(input logic [LVL_W-1:0] param,
                                                        input int unsigned      shift);
    return param << shift;
  endfunction

endpackage

// File: rtl/fx_envelope_detector_if.sv
// Sample/control/result bundle between the sidechain source and the envelope detector.
interface fx_envelope_detector_if #(
  parameter int DATA_W  = 16,
  parameter int PARAM_W = 7
);
  logic                   sample_valid;
  logic [1:0][DATA_W-1:0] audio_in;
  logic [PARAM_W-1:0]     threshold;
  logic [PARAM_W-1:0]     attack;
  // "release" is a reserved word, hence the suffix.
  logic [PARAM_W-1:0]     release_ctl;
  logic [DATA_W-1:0]      env_out;
  logic                   env_valid;
  logic                   over_thresh;
  logic                   busy;
  logic                   overrun;

  modport master (
    output sample_valid, audio_in, threshold, attack, release_ctl,
    input  env_out, env_valid, over_thresh, busy, overrun
  );

  modport slave (
    input  sample_valid, audio_in, threshold, attack, release_ctl,
    output env_out, env_valid, over_thresh, busy, overrun
  );
endinterface

// File: rtl/fx_abs_peak.sv
// Per-lane magnitude of signed samples, then the largest magnitude across lanes.
module fx_abs_peak #(
  parameter int DATA_W    = 16,
  parameter int NUM_LANES = 2
) (
  input  logic [NUM_LANES-1:0][DATA_W-1:0] audio,
  output logic [DATA_W-1:0]                peak
);

  logic [NUM_LANES-1:0][DATA_W-1:0] mag;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    // Negating the most negative value yields 2^(DATA_W-1), which fits unsigned.
    assign mag[i] = audio[i][DATA_W-1] ? (~audio[i] + DATA_W'(1)) : audio[i];
  end

  always_comb begin
    peak = '0;
    for (int i = 0; i < NUM_LANES; i++)
      if (mag[i] > peak) peak = mag[i];
  end

endmodule

// File: rtl/fx_envelope_detector.sv
// Stereo peak detector with attack/release envelope follower and threshold flag.
module fx_envelope_detector
  import fx_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int PARAM_W = 7,
  parameter int FRAC_W  = ENV_FRAC_W
) (
  input  logic                   clk,
  input  logic                   reset,
  fx_envelope_detector_if.slave  bus
);

  localparam int ACC_W = DATA_W + FRAC_W;

  env_state_t             state, state_nxt;
  logic                   accept, ld_peak, ld_env, busy;

  logic [1:0][DATA_W-1:0] audio_q;
  logic [PARAM_W-1:0]     thr_q, atk_q, rel_q;
  logic [DATA_W-1:0]      peak_c, peak_q;

  logic [ACC_W-1:0]       env_acc, acc_nxt, target, diff, step;
  logic [3:0]             ka, kr;
  logic [DATA_W-1:0]      env_nxt, env_q;
  logic                   over_nxt, over_q, env_vld_q, overrun_q;

  fx_abs_peak #(.DATA_W(DATA_W), .NUM_LANES(2)) u_abs_peak (
    .audio (audio_q),
    .peak  (peak_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    ld_peak   = 1'b0;
    ld_env    = 1'b0;
    unique case (state)
      IDLE:    if (bus.sample_valid) begin accept = 1'b1; state_nxt = PEAK; end
      PEAK:    begin ld_peak = 1'b1; state_nxt = SMOOTH; end
      SMOOTH:  begin ld_env  = 1'b1; state_nxt = IDLE;   end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  assign ka = 4'(ATK_SHIFT_BASE) + 4'(atk_q[PARAM_W-1 -: 3]);
  assign kr = 4'(REL_SHIFT_BASE) + 4'(rel_q[PARAM_W-1 -: 3]);

  // Shifted step never overshoots the target; the 1-LSB floor guarantees exact convergence.
  always_comb begin
    target  = {peak_q, {FRAC_W{1'b0}}};
    diff    = '0;
    step    = '0;
    acc_nxt = env_acc;
    if (target > env_acc) begin
      diff = target - env_acc;
      step = diff >> ka;
      if (step == '0) step = ACC_W'(1);
      acc_nxt = env_acc + step;
    end else if (target < env_acc) begin
      diff = env_acc - target;
      step = diff >> kr;
      if (step == '0) step = ACC_W'(1);
      acc_nxt = env_acc - step;
    end
  end

  assign env_nxt  = acc_nxt[ACC_W-1:FRAC_W];
  assign over_nxt = LVL_W'(env_nxt) >= level_from_param(LVL_W'(thr_q), DATA_W - PARAM_W);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      audio_q   <= '0;
      thr_q     <= '0;
      atk_q     <= '0;
      rel_q     <= '0;
      peak_q    <= '0;
      env_acc   <= '0;
      env_q     <= '0;
      over_q    <= 1'b0;
      env_vld_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      env_vld_q <= ld_env;
      if (bus.sample_valid && busy) overrun_q <= 1'b1;
      if (accept) begin
        audio_q <= bus.audio_in;
        thr_q   <= bus.threshold;
        atk_q   <= bus.attack;
        rel_q   <= bus.release_ctl;
      end
      if (ld_peak) peak_q <= peak_c;
      if (ld_env) begin
        env_acc <= acc_nxt;
        env_q   <= env_nxt;
        over_q  <= over_nxt;
      end
    end
  end

  assign bus.env_out     = env_q;
  assign bus.env_valid   = env_vld_q;
  assign bus.over_thresh = over_q;
  assign bus.busy        = busy;
  assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_fx_envelope_detector.sv
// Bench for fx_envelope_detector: vector tables plus hand-built sequences, scoreboard on env_valid.
module tb_fx_envelope_detector;

  localparam int DATA_W  = 16;
  localparam int PARAM_W = 7;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fx_envelope_detector_if #(.DATA_W(DATA_W), .PARAM_W(PARAM_W)) bus ();

  fx_envelope_detector #(.DATA_W(DATA_W), .PARAM_W(PARAM_W), .FRAC_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] l, r;
    logic [6:0]  thr, atk, rel;
    int          env;
    bit          over;
  } vec_t;

  typedef struct {
    int env;
    bit over;
    bit chk;
    int id;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   ncmp  = 0;
  int   nfail = 0;

  function automatic vec_t mk(int l, int r, int thr, int atk, int rel, int env, bit over);
    vec_t v;
    v.l = 16'(l); v.r = 16'(r);
    v.thr = 7'(thr); v.atk = 7'(atk); v.rel = 7'(rel);
    v.env = env; v.over = over;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every env_valid pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (reset === 1'b0 && bus.env_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        ncmp++; nfail++;
        $display("FAIL unexpected_env_valid: got pulse with env_out=%0d, want none", bus.env_out);
      end else begin
        mon_e = sbq.pop_front();
        if (mon_e.chk) begin
          check($sformatf("env_out[%0d]", mon_e.id), 64'(bus.env_out), 64'(mon_e.env));
          check($sformatf("over_thresh[%0d]", mon_e.id), 64'(bus.over_thresh), 64'(mon_e.over));
        end
      end
    end
  end

  task automatic do_reset();
    bus.sample_valid = 1'b0;
    reset = 1'b1;
    sbq.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic send(input vec_t v, input bit chk, input int id);
    int t;
    t = 0;
    while (bus.busy === 1'b1 && t < 10) begin @(negedge clk); t++; end
    if (bus.busy !== 1'b0) begin
      ncmp++; nfail++;
      $display("FAIL send_idle[%0d]: busy=%b, want 0", id, bus.busy);
    end
    bus.audio_in[0]  = v.l;
    bus.audio_in[1]  = v.r;
    bus.threshold    = v.thr;
    bus.attack       = v.atk;
    bus.release_ctl  = v.rel;
    bus.sample_valid = 1'b1;
    sbq.push_back('{env: v.env, over: v.over, chk: chk, id: id});
    @(negedge clk);
    bus.sample_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (sbq.size() != 0 && t < 12) begin @(negedge clk); t++; end
    ncmp++;
    if (sbq.size() != 0) begin
      nfail++;
      $display("FAIL %s_timeout: %0d results pending, want 0", name, sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rise[10];
    vec_t fs[3];
    vec_t v;
    int   pulses;

    rise[0] = mk(16384, -20000, 39, 0, 0, 10000, 0);
    rise[1] = mk(16384, -20000, 39, 0, 0, 15000, 0);
    rise[2] = mk(16384, -20000, 39, 0, 0, 17500, 0);
    rise[3] = mk(16384, -20000, 39, 0, 0, 18750, 0);
    rise[4] = mk(16384, -20000, 39, 0, 0, 19375, 0);
    rise[5] = mk(16384, -20000, 39, 0, 0, 19687, 0);
    rise[6] = mk(16384, -20000, 39, 0, 0, 19843, 0);
    rise[7] = mk(16384, -20000, 39, 0, 0, 19921, 0);
    rise[8] = mk(16384, -20000, 39, 0, 0, 19960, 0);
    rise[9] = mk(16384, -20000, 39, 0, 0, 19980, 1);

    fs[0] = mk(-32768, 0,      0,  0, 0, 16384, 1);
    fs[1] = mk(-32768, 0,      0,  0, 0, 24576, 1);
    fs[2] = mk(32767,  -32768, 64, 0, 0, 28672, 0);

    reset = 1'b1;
    bus.sample_valid = 1'b0;
    bus.audio_in     = '0;
    bus.threshold    = '0;
    bus.attack       = '0;
    bus.release_ctl  = '0;
    repeat (2) @(negedge clk);

    check("rst_env_out",     64'(bus.env_out),     64'd0);
    check("rst_env_valid",   64'(bus.env_valid),   64'd0);
    check("rst_over_thresh", 64'(bus.over_thresh), 64'd0);
    check("rst_busy",        64'(bus.busy),        64'd0);
    check("rst_overrun",     64'(bus.overrun),     64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Attack rise toward 20000, then settle to exactly 20000 and release toward 0.
    for (int i = 0; i < 10; i++) begin
      send(rise[i], 1'b1, i);
      drain("rise");
    end
    for (int i = 10; i < 39; i++) begin
      send(rise[0], 1'b0, i);
      drain("settle");
    end
    send(mk(16384, -20000, 39, 0, 0, 20000, 1), 1'b1, 39);
    drain("settle");
    send(mk(0, 0, 39, 0, 0, 18750, 0), 1'b1, 40);
    drain("release");
    send(mk(0, 0, 39, 0, 0, 17578, 0), 1'b1, 41);
    drain("release");
    check("overrun_clean", 64'(bus.overrun), 64'd0);

    // Full-scale negative input on each channel.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send(fs[i], 1'b1, 100 + i);
      drain("fullscale");
    end

    // sample_valid held high for 9 edges: every third strobe accepted.
    do_reset();
    bus.audio_in[0]  = 16'(20000);
    bus.audio_in[1]  = 16'(20000);
    bus.threshold    = '0;
    bus.attack       = '0;
    bus.release_ctl  = '0;
    sbq.push_back('{env: 10000, over: 1'b1, chk: 1'b1, id: 200});
    sbq.push_back('{env: 15000, over: 1'b1, chk: 1'b1, id: 201});
    sbq.push_back('{env: 17500, over: 1'b1, chk: 1'b1, id: 202});
    bus.sample_valid = 1'b1;
    pulses = 0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      check($sformatf("hs_busy[%0d]", c),      64'(bus.busy),      64'((c % 3) != 2));
      check($sformatf("hs_env_valid[%0d]", c), 64'(bus.env_valid), 64'((c % 3) == 2));
      check($sformatf("hs_overrun[%0d]", c),   64'(bus.overrun),   64'(c >= 1));
      if (bus.env_valid === 1'b1) pulses++;
    end
    bus.sample_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("hs_pulses", 64'(pulses), 64'd3);
    check("hs_overrun_sticky", 64'(bus.overrun), 64'd1);
    drain("handshake");

    // Reset while the sample sits in PEAK.
    do_reset();
    send(mk(16384, -20000, 0, 0, 0, 10000, 1), 1'b1, 300);
    drain("midrst_pre");
    bus.sample_valid = 1'b1;
    @(negedge clk);
    bus.sample_valid = 1'b0;
    check("midrst_in_peak", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    #1;
    check("midrst_busy",    64'(bus.busy),        64'd0);
    check("midrst_env_out", 64'(bus.env_out),     64'd0);
    check("midrst_over",    64'(bus.over_thresh), 64'd0);
    check("midrst_env_acc", 64'(dut.env_acc),     64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("midrst_no_pulse[%0d]", c), 64'(bus.env_valid), 64'd0);
    end
    send(mk(16384, -20000, 0, 0, 0, 10000, 1), 1'b1, 301);
    drain("midrst_post");

    // Controls latched at accept: attack change while busy applies to the next sample.
    do_reset();
    send(mk(16384, -20000, 0, 0, 0, 10000, 1), 1'b1, 400);
    drain("latch");
    v = mk(16384, -20000, 0, 0, 0, 15000, 1);
    send(v, 1'b1, 401);
    bus.attack = 7'd127;
    drain("latch");
    send(mk(16384, -20000, 0, 127, 0, 15019, 1), 1'b1, 402);
    drain("latch");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
